// File: rtl/uc_prog_pkg.sv
// Shared types and default constants for the instruction-memory program loader.
package uc_prog_pkg;
  localparam int          ADDR_W_DEF     = 11;
  localparam int          DATA_W_DEF     = 12;
  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
  localparam logic [8:0]  CNT_ZERO_WORDS = 9'd256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S_AHI,
    ST_S_ALO,
    ST_S_CNT,
    ST_D_LO,
    ST_D_HI,
    ST_WR,
    ST_S_CSUM,
    ST_DONE
  } state_e;
endpackage

// File: rtl/uc_prog_csum.sv
// Modulo-256 byte accumulator used to validate the frame checksum.
module uc_prog_csum (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_zero
);
  logic [7:0] r_sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_sum <= 8'h00;
    else if (i_clr) r_sum <= 8'h00;
    else if (i_add) r_sum <= r_sum + i_byte;
  end

  assign o_zero = (r_sum == 8'h00);
endmodule

// File: rtl/uc_prog_loader.sv
// Framed byte-stream loader writing 12-bit words into the core's instruction store.
// Define UC_PROG_LOADER_CSUM_EN to expect a trailing checksum byte and enable err.
module uc_prog_loader
  import uc_prog_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         DATA_W    = DATA_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              core_hold,
  output logic              done,
  output logic              err
);
`ifdef UC_PROG_LOADER_CSUM_EN
  localparam state_e END_ST = ST_S_CSUM;
`else
  localparam state_e END_ST = ST_DONE;
`endif

  state_e            r_state, w_next;
  logic              r_live;
  logic [ADDR_W-9:0] r_ahi;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dlo;
  logic [DATA_W-1:0] r_wdata;
  logic [8:0]        r_rem;
  logic              w_acc, w_last, w_sum_ok;

  assign w_acc  = in_valid && in_ready;
  assign w_last = (r_rem == 9'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_acc && in_data == SYNC_BYTE) w_next = ST_S_AHI;
      ST_S_AHI:  if (w_acc) w_next = ST_S_ALO;
      ST_S_ALO:  if (w_acc) w_next = ST_S_CNT;
      ST_S_CNT:  if (w_acc) w_next = ST_D_LO;
      ST_D_LO:   if (w_acc) w_next = ST_D_HI;
      ST_D_HI:   if (w_acc) w_next = ST_WR;
      ST_WR:     if (wr_ready) w_next = w_last ? END_ST : ST_D_LO;
      ST_S_CSUM: if (w_acc) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // r_live keeps in_ready low while reset is held, independent of state decode.
  assign in_ready  = r_live && (r_state != ST_WR) && (r_state != ST_DONE);
  assign wr_en     = (r_state == ST_WR);
  assign core_hold = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign wr_addr   = r_addr;
  assign wr_data   = r_wdata;
  assign done      = (r_state == ST_DONE) && w_sum_ok;
  assign err       = (r_state == ST_DONE) && !w_sum_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_live  <= 1'b0;
      r_ahi   <= '0;
      r_addr  <= '0;
      r_dlo   <= '0;
      r_wdata <= '0;
      r_rem   <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_S_AHI: if (w_acc) r_ahi <= in_data[ADDR_W-9:0];
        ST_S_ALO: if (w_acc) r_addr <= {r_ahi, in_data};
        ST_S_CNT: if (w_acc) r_rem <= (in_data == 8'h00) ? CNT_ZERO_WORDS : {1'b0, in_data};
        ST_D_LO:  if (w_acc) r_dlo <= in_data;
        ST_D_HI:  if (w_acc) r_wdata <= {in_data[DATA_W-9:0], r_dlo};
        ST_WR: if (wr_ready) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_rem  <= r_rem - 9'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef UC_PROG_LOADER_CSUM_EN
  // Sum restarts on SYNC and covers every later byte, including CSUM itself.
  uc_prog_csum u_csum (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_acc && r_state == ST_IDLE),
    .i_add  (w_acc && r_state != ST_IDLE),
    .i_byte (in_data),
    .o_zero (w_sum_ok)
  );
`else
  assign w_sum_ok = 1'b1;
`endif
endmodule

// File: tb/tb_uc_prog_loader.sv
// Directed self-checking bench for uc_prog_loader (adapts to UC_PROG_LOADER_CSUM_EN).
module tb_uc_prog_loader;
`ifdef UC_PROG_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        core_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [22:0] wq[$];
  logic [7:0]  f_lo[256];
  logic [7:0]  f_hi[256];

  uc_prog_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Handshakes/pulses seen at the negedge complete on the following posedge.
  always @(negedge clock) begin
    if (wr_en && wr_ready) wq.push_back({wr_addr, wr_data});
    if (done) n_done++;
    if (err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 64) begin step(); n++; end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] ahi, input logic [7:0] alo,
                           input logic [7:0] cnt, input logic corrupt);
    int   nw, d0, e0, bad, hold_bad;
    logic [7:0]  sum;
    logic [10:0] a;
    logic [22:0] exp_w;
    nw = (cnt == 8'h00) ? 256 : int'(cnt);
    d0 = n_done; e0 = n_err; bad = -1; hold_bad = 0;
    wq.delete();
    wr_ready = 1'b1;
    send_byte(8'hA5);
    check("hold_rise", {31'd0, core_hold}, 32'd1);
    send_byte(ahi); send_byte(alo); send_byte(cnt);
    sum = ahi + alo + cnt;
    for (int i = 0; i < nw; i++) begin
      send_byte(f_lo[i]);
      send_byte(f_hi[i]);
      sum = sum + f_lo[i] + f_hi[i];
      if (!core_hold) hold_bad++;
    end
    check("hold_frame", hold_bad, 0);
    if (CSUM_ON) send_byte(8'(-sum) + {7'd0, corrupt});
    else         step();
    check("end_done", {31'd0, done}, {31'd0, !(corrupt && CSUM_ON)});
    check("end_err",  {31'd0, err},  {31'd0, corrupt && CSUM_ON});
    check("end_hold", {31'd0, core_hold}, 32'd0);
    step();
    check("pulse_len", {30'd0, done, err}, 32'd0);
    check("rdy_after", {31'd0, in_ready}, 32'd1);
    check("n_done", n_done - d0, (corrupt && CSUM_ON) ? 0 : 1);
    check("n_err",  n_err - e0,  (corrupt && CSUM_ON) ? 1 : 0);
    check("wr_cnt", wq.size(), nw);
    a = {ahi[2:0], alo};
    for (int i = 0; i < nw; i++) begin
      exp_w = {a, f_hi[i][3:0], f_lo[i]};
      if (bad < 0 && (i >= wq.size() || wq[i] !== exp_w)) bad = i;
      a = a + 11'd1;
    end
    check("wr_first_bad", bad, 32'hFFFF_FFFF);
  endtask

  task automatic load_frame_a();
    f_lo[0] = 8'h34; f_hi[0] = 8'hF1;
    f_lo[1] = 8'h78; f_hi[1] = 8'h02;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_outs", {in_ready, wr_en, wr_addr, wr_data, core_hold, done, err}, 32'd0);
    reset = 1'b0;
    step();
    check("rdy_post_rst", {31'd0, in_ready}, 32'd1);
    check("hold_post_rst", {31'd0, core_hold}, 32'd0);

    // Frame A, good checksum (byte sum 0xB1 -> CSUM 0x4F)
    load_frame_a();
    run_frame(8'h00, 8'h10, 8'h02, 1'b0);
    check("a_w0", wq[0], {11'h010, 12'h134});
    check("a_w1", wq[1], {11'h011, 12'h278});

    // Frame A, corrupted checksum: writes still land
    run_frame(8'h00, 8'h10, 8'h02, 1'b1);

    // Garbage before SYNC is discarded
    wq.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("garb_hold", {31'd0, core_hold}, 32'd0);
    check("garb_wr", wq.size(), 0);
    run_frame(8'h00, 8'h10, 8'h02, 1'b0);

    // Address wrap with stalled writes; ADDR_HI upper bits ignored
    wq.delete();
    wr_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'hAB); send_byte(8'h0C);
    check("st0_wr_en", {31'd0, wr_en}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("st0_hold", {in_ready, wr_en, wr_addr, wr_data}, {1'b0, 1'b1, 11'h7FF, 12'hCAB});
    end
    wr_ready = 1'b1; step(); wr_ready = 1'b0;
    send_byte(8'hCD); send_byte(8'h1E);
    for (int k = 0; k < 3; k++) begin
      step();
      check("st1_hold", {in_ready, wr_en, wr_addr, wr_data}, {1'b0, 1'b1, 11'h000, 12'hECD});
    end
    wr_ready = 1'b1; step();
    // bytes after SYNC: FF FF 02 AB 0C CD 1E sum 0xA2 -> CSUM 0x5E
    if (CSUM_ON) begin
      check("st_csum_rdy", {31'd0, in_ready}, 32'd1);
      send_byte(8'h5E);
    end
    check("st_done", {31'd0, done}, 32'd1);
    check("st_w0", wq[0], {11'h7FF, 12'hCAB});
    check("st_w1", wq[1], {11'h000, 12'hECD});
    check("st_cnt", wq.size(), 2);
    step();

    // COUNT = 0 means 256 words
    for (int i = 0; i < 256; i++) begin
      f_lo[i] = 8'(i);
      f_hi[i] = 8'(i * 7);
    end
    run_frame(8'h02, 8'h00, 8'h00, 1'b0);

    // Reset during a pending write
    wq.delete();
    wr_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'hF1);
    check("mid_wr_en", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_async", {in_ready, wr_en, wr_addr, wr_data, core_hold, done, err}, 32'd0);
    step();
    check("mid_rst_edge", {in_ready, wr_en, wr_addr, wr_data, core_hold, done, err}, 32'd0);
    check("mid_no_wr", wq.size(), 0);
    reset = 1'b0;
    step();
    check("mid_rdy", {31'd0, in_ready}, 32'd1);
    load_frame_a();
    run_frame(8'h00, 8'h10, 8'h02, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
